// File: rtl/board_render.sv
// Playfield renderer: cell-code array with write port and line-clear FSM,
// plus a 2-stage pixel pipeline mapping (x,y) to an RGB colour.
module board_render #(
  parameter int COLS      = 10,
  parameter int ROWS      = 20,
  parameter int CELL_LOG2 = 4,
  parameter int X0        = 220,
  parameter int Y0        = 60,
  parameter int GRID      = 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [9:0]               x,
  input  logic [9:0]               y,
  input  logic                     i_wr_en,
  input  logic [$clog2(COLS)-1:0]  i_wr_col,
  input  logic [$clog2(ROWS)-1:0]  i_wr_row,
  input  logic [2:0]               i_wr_code,
  input  logic                     i_clr_start,
  input  logic [$clog2(ROWS)-1:0]  i_clr_row,
  output logic [7:0]               o_vga_r,
  output logic [7:0]               o_vga_g,
  output logic [7:0]               o_vga_b,
  output logic                     o_busy,
  output logic                     o_done,
  output logic [ROWS-1:0]          o_row_full
);

  localparam int CW   = $clog2(COLS);
  localparam int RW   = $clog2(ROWS);
  localparam int CELL = 1 << CELL_LOG2;

  localparam logic [CW:0]  LP_COLS = (CW+1)'(COLS);
  localparam logic [RW:0]  LP_ROWS = (RW+1)'(ROWS);
  localparam logic [10:0]  LP_X0   = 11'(X0);
  localparam logic [10:0]  LP_Y0   = 11'(Y0);
  localparam logic [10:0]  LP_XW   = 11'(COLS * CELL);
  localparam logic [10:0]  LP_YH   = 11'(ROWS * CELL);

  typedef enum logic [1:0] {IDLE, SHIFT, TOP} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [RW-1:0]   r_row;
  logic [RW-1:0]   w_row_m1;
  logic            r_done;
  logic [2:0]      r_cells [ROWS][COLS];

  logic            w_idle;
  logic            w_clr_acc;
  logic            w_wr_acc;

  assign w_idle    = (r_state == IDLE);
  assign w_row_m1  = r_row - RW'(1);
  assign w_clr_acc = w_idle && i_clr_start && ({1'b0, i_clr_row} < LP_ROWS);
  assign w_wr_acc  = w_idle && i_wr_en && !w_clr_acc &&
                     ({1'b0, i_wr_col} < LP_COLS) && ({1'b0, i_wr_row} < LP_ROWS);

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic; a clear of row 0 has nothing to shift and goes straight to TOP
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_clr_acc) w_next = (i_clr_row == '0) ? TOP : SHIFT;
      SHIFT:   if (r_row == RW'(1)) w_next = TOP;
      TOP:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Status outputs, forced low while reset is held
  always_comb begin
    o_busy = (r_state != IDLE) && !i_rst;
    o_done = r_done && !i_rst;
  end

  // Cell array, shift-row pointer and completion flag
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned r = 0; r < ROWS; r++)
        for (int unsigned c = 0; c < COLS; c++)
          r_cells[r][c] <= '0;
      r_row  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= (r_state == TOP);
      case (r_state)
        IDLE: begin
          if (w_clr_acc)     r_row <= i_clr_row;
          else if (w_wr_acc) r_cells[i_wr_row][i_wr_col] <= i_wr_code;
        end
        SHIFT: begin
          for (int unsigned c = 0; c < COLS; c++)
            r_cells[r_row][c] <= r_cells[w_row_m1][c];
          r_row <= w_row_m1;
        end
        TOP: begin
          for (int unsigned c = 0; c < COLS; c++)
            r_cells[0][c] <= '0;
        end
        default: ;
      endcase
    end
  end

  // Row-full flags straight from the array
  always_comb begin
    o_row_full = '0;
    for (int unsigned r = 0; r < ROWS; r++) begin
      o_row_full[r] = 1'b1;
      for (int unsigned c = 0; c < COLS; c++)
        if (r_cells[r][c] == '0) o_row_full[r] = 1'b0;
    end
  end

  // Pixel stage 1: field membership, cell index and grid flag
  logic [10:0]    w_dx, w_dy;
  logic           w_in, w_grid;
  logic           r_s1_in, r_s1_grid;
  logic [CW-1:0]  r_s1_col;
  logic [RW-1:0]  r_s1_row;

  assign w_dx   = {1'b0, x} - LP_X0;
  assign w_dy   = {1'b0, y} - LP_Y0;
  assign w_in   = ({1'b0, x} >= LP_X0) && (w_dx < LP_XW) &&
                  ({1'b0, y} >= LP_Y0) && (w_dy < LP_YH);
  assign w_grid = (w_dx[CELL_LOG2-1:0] == '0) || (w_dy[CELL_LOG2-1:0] == '0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1_in   <= 1'b0;
      r_s1_grid <= 1'b0;
      r_s1_col  <= '0;
      r_s1_row  <= '0;
    end else begin
      r_s1_in   <= w_in;
      r_s1_grid <= w_grid;
      r_s1_col  <= w_dx[CELL_LOG2 +: CW];
      r_s1_row  <= w_dy[CELL_LOG2 +: RW];
    end
  end

  // Pixel stage 2: palette lookup and colour priority
  logic [2:0]  w_code;
  logic [23:0] w_pal, w_rgb, r_rgb;

  always_comb begin
    w_code = r_s1_in ? r_cells[r_s1_row][r_s1_col] : 3'd0;
    case (w_code)
      3'd0:    w_pal = 24'hFFFF00;
      3'd1:    w_pal = 24'h00FFFF;
      3'd2:    w_pal = 24'h0000FF;
      3'd3:    w_pal = 24'hFF8000;
      3'd4:    w_pal = 24'h00FF00;
      3'd5:    w_pal = 24'hFF0000;
      3'd6:    w_pal = 24'h8000FF;
      default: w_pal = 24'h404040;
    endcase
    if (!r_s1_in)                     w_rgb = 24'hFFFFFF;
    else if ((GRID != 0) && r_s1_grid) w_rgb = 24'h808080;
    else                              w_rgb = w_pal;
  end

  // Registered output colour
  always_ff @(posedge i_clk) begin
    if (i_rst) r_rgb <= '0;
    else       r_rgb <= w_rgb;
  end

  assign o_vga_r = r_rgb[23:16];
  assign o_vga_g = r_rgb[15:8];
  assign o_vga_b = r_rgb[7:0];

endmodule

// File: tb/tb_board_render.sv
// Self-checking bench for board_render: pixel scoreboard plus FSM scenarios.
module tb_board_render;

  localparam int COLS = 10;
  localparam int ROWS = 20;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [9:0]  x = '0, y = '0;
  logic        i_wr_en = 1'b0;
  logic [3:0]  i_wr_col = '0;
  logic [4:0]  i_wr_row = '0;
  logic [2:0]  i_wr_code = '0;
  logic        i_clr_start = 1'b0;
  logic [4:0]  i_clr_row = '0;
  logic [7:0]  o_vga_r, o_vga_g, o_vga_b;
  logic        o_busy, o_done;
  logic [19:0] o_row_full;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  logic [2:0] m_cells [ROWS][COLS];

  typedef struct {
    int          px;
    int          py;
    int          cyc;
    logic [23:0] rgb;
  } pix_t;
  pix_t q_exp[$];

  board_render #(.COLS(10), .ROWS(20), .CELL_LOG2(4), .X0(220), .Y0(60), .GRID(1)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .x(x), .y(y),
    .i_wr_en(i_wr_en), .i_wr_col(i_wr_col), .i_wr_row(i_wr_row), .i_wr_code(i_wr_code),
    .i_clr_start(i_clr_start), .i_clr_row(i_clr_row),
    .o_vga_r(o_vga_r), .o_vga_g(o_vga_g), .o_vga_b(o_vga_b),
    .o_busy(o_busy), .o_done(o_done), .o_row_full(o_row_full)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  function automatic logic [23:0] pal(input logic [2:0] c);
    case (c)
      3'd0: return 24'hFFFF00;
      3'd1: return 24'h00FFFF;
      3'd2: return 24'h0000FF;
      3'd3: return 24'hFF8000;
      3'd4: return 24'h00FF00;
      3'd5: return 24'hFF0000;
      3'd6: return 24'h8000FF;
      default: return 24'h404040;
    endcase
  endfunction

  function automatic logic [23:0] exp_pix(input int px, input int py);
    if (px < 220 || px >= 380 || py < 60 || py >= 380) return 24'hFFFFFF;
    if (((px - 220) % 16) == 0 || ((py - 60) % 16) == 0) return 24'h808080;
    return pal(m_cells[(py - 60) / 16][(px - 220) / 16]);
  endfunction

  function automatic logic [19:0] exp_full();
    logic [19:0] f;
    f = '0;
    for (int r = 0; r < ROWS; r++) begin
      f[r] = 1'b1;
      for (int c = 0; c < COLS; c++) if (m_cells[r][c] == 3'd0) f[r] = 1'b0;
    end
    return f;
  endfunction

  function automatic void model_clear(input int row);
    for (int r = row; r >= 1; r--)
      for (int c = 0; c < COLS; c++) m_cells[r][c] = m_cells[r-1][c];
    for (int c = 0; c < COLS; c++) m_cells[0][c] = 3'd0;
  endfunction

  // Compare every queued pixel whose result is now due (2 cycles after drive)
  task automatic pix_pop_due();
    pix_t e;
    logic [23:0] got;
    while (q_exp.size() > 0 && (cyc - q_exp[0].cyc) >= 2) begin
      e = q_exp.pop_front();
      got = {o_vga_r, o_vga_g, o_vga_b};
      n_chk++;
      if (got !== e.rgb)
        $display("FAIL pixel x=%0d y=%0d: got %h required %h", e.px, e.py, got, e.rgb);
      else n_pass++;
    end
  endtask

  task automatic pix_drive(input int px, input int py);
    pix_t e;
    @(negedge i_clk);
    pix_pop_due();
    x = 10'(px);
    y = 10'(py);
    e.px = px; e.py = py; e.cyc = cyc; e.rgb = exp_pix(px, py);
    q_exp.push_back(e);
  endtask

  task automatic pix_flush();
    for (int k = 0; k < 6 && q_exp.size() > 0; k++) begin
      @(negedge i_clk);
      pix_pop_due();
    end
    n_chk++;
    if (q_exp.size() != 0) begin
      $display("FAIL pix_flush: got %0d pending required 0", q_exp.size());
      q_exp.delete();
    end else n_pass++;
  endtask

  task automatic check_cells(input string tag);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        pix_drive(220 + c*16 + 5, 60 + r*16 + 5);
    pix_flush();
    n_chk++;
    if (o_row_full !== exp_full())
      $display("FAIL row_full %s: got %h required %h", tag, o_row_full, exp_full());
    else n_pass++;
  endtask

  task automatic do_write(input int col, input int row, input int code);
    @(negedge i_clk);
    i_wr_en = 1'b1; i_wr_col = 4'(col); i_wr_row = 5'(row); i_wr_code = 3'(code);
    @(negedge i_clk);
    i_wr_en = 1'b0;
    if (col < COLS && row < ROWS) m_cells[row][col] = 3'(code);
  endtask

  // Issue a clear and count busy/done cycles from the cycle after the request
  task automatic run_clear(input int row, input int exp_busy, input int exp_done, input string tag);
    int nb, nd, di;
    nb = 0; nd = 0; di = -1;
    @(negedge i_clk);
    i_clr_start = 1'b1; i_clr_row = 5'(row);
    @(negedge i_clk);
    i_clr_start = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (o_busy) nb++;
      if (o_done) begin nd++; if (di < 0) di = k; end
      @(negedge i_clk);
    end
    n_chk++;
    if (nb != exp_busy) $display("FAIL %s busy_cycles: got %0d required %0d", tag, nb, exp_busy);
    else n_pass++;
    n_chk++;
    if (nd != exp_done) $display("FAIL %s done_pulses: got %0d required %0d", tag, nd, exp_done);
    else n_pass++;
    if (exp_done == 1) begin
      n_chk++;
      if (di != exp_busy) $display("FAIL %s done_position: got %0d required %0d", tag, di, exp_busy);
      else n_pass++;
    end
    if (row < ROWS) model_clear(row);
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    repeat (4) @(negedge i_clk);
    n_chk++;
    if ({o_vga_r, o_vga_g, o_vga_b} !== 24'h0) $display("FAIL reset_rgb: got %h required 000000", {o_vga_r, o_vga_g, o_vga_b});
    else n_pass++;
    n_chk++;
    if ({o_busy, o_done} !== 2'b00) $display("FAIL reset_status: got %b required 00", {o_busy, o_done});
    else n_pass++;
    n_chk++;
    if (o_row_full !== 20'h0) $display("FAIL reset_row_full: got %h required 00000", o_row_full);
    else n_pass++;
    for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) m_cells[r][c] = 3'd0;
    i_rst = 1'b0;
  endtask

  task automatic test_sweep();
    int ys[11] = '{0, 59, 60, 61, 75, 76, 77, 200, 379, 380, 479};
    int xs[9]  = '{0, 219, 220, 221, 235, 236, 379, 380, 639};
    foreach (ys[i]) for (int px = 0; px < 640; px += 3) pix_drive(px, ys[i]);
    foreach (xs[i]) for (int py = 0; py < 480; py += 3) pix_drive(xs[i], py);
    pix_flush();
  endtask

  task automatic test_write();
    do_write(3, 7, 5);
    pix_drive(220 + 3*16 + 5, 60 + 7*16 + 5);
    pix_drive(220 + 3*16, 60 + 7*16 + 5);
    pix_drive(220 + 4*16 + 5, 60 + 7*16 + 5);
    pix_flush();
    do_write(12, 3, 6);
    do_write(2, 22, 6);
    check_cells("write");
  endtask

  task automatic test_clear_row19();
    for (int c = 0; c < COLS; c++) do_write(c, 19, 2);
    do_write(0, 18, 4);
    @(negedge i_clk);
    n_chk++;
    if (o_row_full[19] !== 1'b1) $display("FAIL row19_full_before: got %b required 1", o_row_full[19]);
    else n_pass++;
    run_clear(19, 20, 1, "clear19");
    n_chk++;
    if (m_cells[19][0] !== 3'd4) $display("FAIL model_row19: got %0d required 4", m_cells[19][0]);
    else n_pass++;
    check_cells("clear19");
  endtask

  task automatic test_clear_row0();
    do_write(2, 0, 3);
    check_cells("pre_clear0");
    run_clear(0, 1, 1, "clear0");
    check_cells("clear0");
    run_clear(25, 0, 0, "clear25");
    check_cells("clear25");
  endtask

  task automatic test_back_to_back();
    int nb;
    logic seen_done;
    nb = 0; seen_done = 1'b0;
    @(negedge i_clk);
    i_clr_start = 1'b1; i_clr_row = 5'd3;
    i_wr_en = 1'b1; i_wr_col = 4'd5; i_wr_row = 5'd10; i_wr_code = 3'd6;
    @(negedge i_clk);
    i_clr_start = 1'b0;
    i_wr_col = 4'd1; i_wr_row = 5'd15; i_wr_code = 3'd7;
    n_chk++;
    if (o_busy !== 1'b1) $display("FAIL conflict_busy: got %b required 1", o_busy);
    else n_pass++;
    @(negedge i_clk);
    i_wr_en = 1'b0;
    for (int k = 0; k < 20 && !seen_done; k++) begin
      if (o_done) seen_done = 1'b1;
      @(negedge i_clk);
    end
    n_chk++;
    if (!seen_done) $display("FAIL conflict_done: got 0 required 1");
    else n_pass++;
    model_clear(3);
    check_cells("conflict");
  endtask

  task automatic test_reset_in_shift();
    int nd;
    nd = 0;
    for (int c = 0; c < COLS; c++) do_write(c, 19, 1);
    @(negedge i_clk);
    i_clr_start = 1'b1; i_clr_row = 5'd19;
    @(negedge i_clk);
    i_clr_start = 1'b0;
    repeat (4) @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    n_chk++;
    if (o_busy !== 1'b0) $display("FAIL rst_shift_busy: got %b required 0", o_busy);
    else n_pass++;
    i_rst = 1'b0;
    for (int k = 0; k < 25; k++) begin
      if (o_done) nd++;
      @(negedge i_clk);
    end
    n_chk++;
    if (nd != 0) $display("FAIL rst_shift_done: got %0d required 0", nd);
    else n_pass++;
    n_chk++;
    if (o_row_full !== 20'h0) $display("FAIL rst_shift_row_full: got %h required 00000", o_row_full);
    else n_pass++;
    for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) m_cells[r][c] = 3'd0;
    check_cells("rst_shift");
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_write();
    test_clear_row19();
    test_clear_row0();
    test_back_to_back();
    test_reset_in_shift();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/board_render.md
BOARD_RENDER -- requirements
Module: board_render

Interface
REQ-001 The parameter COLS SHALL default to 10 and set the playfield width in cells.
REQ-002 The parameter ROWS SHALL default to 20 and set the playfield height in cells.
REQ-003 The parameter CELL_LOG2 SHALL default to 4 and set the cell edge to 2^CELL_LOG2 pixels.
REQ-004 The parameters X0 and Y0 SHALL default to 220 and 60 and set the field's top-left pixel.
REQ-005 The parameter GRID SHALL default to 1; 1 enables grid lines and 0 disables them.
REQ-006 The port i_clk SHALL be a 1-bit input and the sole clock; all state updates on its rising edge.
REQ-007 The port i_rst SHALL be a 1-bit input reset, synchronous and active-high.
REQ-008 The ports x and y SHALL be 10-bit inputs giving the current pixel coordinate.
REQ-009 The ports i_wr_en (1), i_wr_col ($clog2(COLS)), i_wr_row ($clog2(ROWS)) and i_wr_code (3) SHALL be inputs forming the cell write port.
REQ-010 The ports i_clr_start (1) and i_clr_row ($clog2(ROWS)) SHALL be inputs that request a line-clear of one row.
REQ-011 The ports o_vga_r, o_vga_g and o_vga_b SHALL be 8-bit outputs carrying the registered pixel colour.
REQ-012 The port o_busy SHALL be a 1-bit output that is high while a line-clear runs.
REQ-013 The port o_done SHALL be a 1-bit output that pulses for one cycle when a line-clear completes.
REQ-014 The port o_row_full SHALL be a ROWS-bit output; bit r is high when every cell in row r is nonzero.

Function
REQ-015 The block SHALL store a COLS x ROWS array of 3-bit cell codes; code 0 means empty.
REQ-016 When idle with i_wr_en high and indices in range, the block SHALL write i_wr_code to the cell, visible the next cycle.
REQ-017 The block SHALL ignore writes with an out-of-range column or row, and any write issued while o_busy is high.
REQ-018 The FSM SHALL have states IDLE, SHIFT and TOP.
REQ-019 In IDLE, i_clr_start with i_clr_row < ROWS SHALL be accepted; the FSM enters SHIFT, or enters TOP directly when i_clr_row = 0.
REQ-020 In SHIFT, the block SHALL copy row r-1 into row r once per cycle, with r starting at i_clr_row and decrementing to 1, then enter TOP.
REQ-021 In TOP, the block SHALL zero row 0 and return to IDLE.
REQ-022 o_busy SHALL be high in SHIFT and TOP, giving i_clr_row+1 cycles starting the cycle after acceptance.
REQ-023 o_done SHALL be high exactly on the first IDLE cycle after TOP.
REQ-024 A request with i_clr_row >= ROWS, or any request while busy, SHALL be ignored without a pulse on o_done.
REQ-025 When i_clr_start and i_wr_en are both high in IDLE, the clear SHALL win and the write SHALL be dropped.
REQ-026 The pixel path SHALL be a 2-stage pipeline, so o_vga_* reflects the x and y presented two cycles earlier.
REQ-027 Stage 1 SHALL register in_field = (X0 <= x < X0+COLS*2^CELL_LOG2) && (Y0 <= y < Y0+ROWS*2^CELL_LOG2), col = (x-X0)>>CELL_LOG2, row = (y-Y0)>>CELL_LOG2, and an on_grid flag (low CELL_LOG2 bits of x-X0 or y-Y0 equal to 0).
REQ-028 Stage 2 SHALL register the pixel colour in this priority order:
- outside the field: (255,255,255);
- GRID=1 and on_grid: (128,128,128);
- otherwise the palette entry for the cell code.
REQ-029 The palette SHALL map each cell code to (R,G,B) as follows: 0 (255,255,0), 1 (0,255,255), 2 (0,0,255), 3 (255,128,0), 4 (0,255,0), 5 (255,0,0), 6 (128,0,255), 7 (64,64,64).
REQ-030 The pixel path SHALL read the array as it stands each cycle; cells changed by a clear or write SHALL appear at most 2 cycles later.
REQ-031 The o_row_full output SHALL be combinational from the array contents.

Reset
REQ-032 While i_rst is high, the block SHALL zero all cells, put the FSM in IDLE, drive o_busy and o_done to 0, and drive o_vga_* and both pipeline stages to 0.
REQ-033 An assertion of i_rst in SHIFT or TOP SHALL abort the clear with no pulse on o_done.
REQ-034 After i_rst falls, o_vga_* SHALL show valid colour from the second cycle onward.

Verification
REQ-035 The bench SHALL reset, then sweep x and y over 640x480 -> field pixels are (255,255,0) or grid (128,128,128), outside pixels are (255,255,255), and each result is 2 cycles after its input.
REQ-036 The bench SHALL write code 5 to column 3, row 7 and then drive x=220+3*16+5 and y=60+7*16+5 -> (255,0,0) two cycles later.
REQ-037 The bench SHALL fill row 19 with code 2, put code 4 at column 0 of row 18, then clear row 19 -> o_row_full[19]=1 before the clear, o_busy high for 20 cycles, o_done for 1 cycle, row 19 column 0 = 4 afterwards, and row 0 all zero.
REQ-038 The bench SHALL request a clear of row 0 -> o_busy high for 1 cycle and row 0 zeroed; a clear of row 25 -> no busy and no done.
REQ-039 The bench SHALL assert i_clr_start together with i_wr_en in IDLE, and issue a write while busy -> both writes are dropped.
REQ-040 The bench SHALL assert i_rst during SHIFT -> o_busy=0 next cycle, no o_done pulse, all cells 0, and o_row_full=0.
